// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART definitions
// Purpose: state encodings and constants shared by the UART receiver and transmitter.
// Ports: none (package).
package uart_pkg;

  localparam int UART_DATA_BITS = 8;
  localparam int UART_MIN_CPB   = 4;

  typedef enum logic [2:0] {
    RX_IDLE      = 3'd0,
    RX_START     = 3'd1,
    RX_DATA      = 3'd2,
    RX_STOP      = 3'd3,
    RX_WAIT_HIGH = 3'd4
  } rx_state_t;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

endpackage

// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - receiver pin, divisor and byte-delivery bundle
// Purpose: groups the serial input, bit divisor and received-byte outputs.
// Ports (signals):
//   i_UART_RX     serial input, idle high
//   i_ClksPerBit  clocks per bit (4..65535)
//   o_Data        last correctly framed byte
//   o_Valid       one-cycle strobe: o_Data updated
//   o_FrameErr    one-cycle strobe: stop bit low, frame discarded
//   o_Idle        receiver waiting for a start bit
// Modports: slave = receiver side, master = peripheral/host side.
interface uart_rx_if;
  import uart_pkg::*;

  logic                      i_UART_RX;
  logic [15:0]               i_ClksPerBit;
  logic [UART_DATA_BITS-1:0] o_Data;
  logic                      o_Valid;
  logic                      o_FrameErr;
  logic                      o_Idle;

  modport slave (
    input  i_UART_RX, i_ClksPerBit,
    output o_Data, o_Valid, o_FrameErr, o_Idle
  );

  modport master (
    output i_UART_RX, i_ClksPerBit,
    input  o_Data, o_Valid, o_FrameErr, o_Idle
  );

endinterface

// File: rtl/uart_sync.sv
// rtl/uart_sync.sv - flop-chain synchroniser for asynchronous inputs
// Purpose: brings an asynchronous level into i_Clk; resets to 1 (idle line level).
// Ports:
//   i_Clk    clock
//   i_Rst    synchronous active-high reset
//   i_Async  asynchronous input
//   o_Sync   i_Async delayed STAGES clocks
module uart_sync #(
  parameter int STAGES = 2
) (
  input  logic i_Clk,
  input  logic i_Rst,
  input  logic i_Async,
  output logic o_Sync
);

  logic [STAGES-1:0] r_Chain;

  always_ff @(posedge i_Clk) begin
    if (i_Rst) r_Chain <= '1;
    else       r_Chain <= {r_Chain[STAGES-2:0], i_Async};
  end

  assign o_Sync = r_Chain[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver, LSB first
// Purpose: validates the start bit at its midpoint, samples data and stop
//   bits at bit centres, delivers each byte with a one-cycle strobe.
// Ports:
//   i_Clk   clock
//   i_Rst   synchronous active-high reset
//   rx      uart_rx_if.slave (pin, divisor, byte outputs)
module uart_rx import uart_pkg::*; #(
  parameter int SYNC_STAGES = 2
) (
  input  logic      i_Clk,
  input  logic      i_Rst,
  uart_rx_if.slave  rx
);

  logic                      r_RxSync;
  rx_state_t                 r_State, w_State_Nxt;
  logic [15:0]               r_Cnt, w_Cnt_Nxt;
  logic [15:0]               r_Cpb, w_Cpb_Nxt;
  logic [15:0]               w_Half, w_Limit;
  logic [2:0]                r_Idx, w_Idx_Nxt;
  logic [UART_DATA_BITS-1:0] r_Shift, w_Shift_Nxt;
  logic [UART_DATA_BITS-1:0] r_Data, w_Data_Nxt;
  logic                      r_Valid, w_Valid_Nxt;
  logic                      r_FrameErr, w_FrameErr_Nxt;
  logic                      w_PeriodEnd;

  uart_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .i_Clk   (i_Clk),
    .i_Rst   (i_Rst),
    .i_Async (rx.i_UART_RX),
    .o_Sync  (r_RxSync)
  );

  // Divisor is latched at frame start, so the whole frame uses one bit time.
  assign w_Half      = r_Cpb >> 1;
  assign w_Limit     = (r_State == RX_START) ? w_Half : r_Cpb;
  assign w_PeriodEnd = (r_Cnt == w_Limit - 16'd1);

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_State    <= RX_IDLE;
      r_Cnt      <= '0;
      r_Cpb      <= '0;
      r_Idx      <= '0;
      r_Shift    <= '0;
      r_Data     <= '0;
      r_Valid    <= 1'b0;
      r_FrameErr <= 1'b0;
    end else begin
      r_State    <= w_State_Nxt;
      r_Cnt      <= w_Cnt_Nxt;
      r_Cpb      <= w_Cpb_Nxt;
      r_Idx      <= w_Idx_Nxt;
      r_Shift    <= w_Shift_Nxt;
      r_Data     <= w_Data_Nxt;
      r_Valid    <= w_Valid_Nxt;
      r_FrameErr <= w_FrameErr_Nxt;
    end
  end

  always_comb begin
    w_State_Nxt    = r_State;
    w_Cnt_Nxt      = w_PeriodEnd ? 16'd0 : r_Cnt + 16'd1;
    w_Cpb_Nxt      = r_Cpb;
    w_Idx_Nxt      = r_Idx;
    w_Shift_Nxt    = r_Shift;
    w_Data_Nxt     = r_Data;
    w_Valid_Nxt    = 1'b0;
    w_FrameErr_Nxt = 1'b0;

    unique case (r_State)
      RX_IDLE: begin
        w_Cnt_Nxt = '0;
        if (!r_RxSync) begin
          w_State_Nxt = RX_START;
          w_Cpb_Nxt   = rx.i_ClksPerBit;
          w_Idx_Nxt   = '0;
        end
      end
      RX_START: begin
        // Line high again at mid start bit: treat as a glitch.
        if (w_PeriodEnd) begin
          w_State_Nxt = r_RxSync ? RX_IDLE : RX_DATA;
          w_Idx_Nxt   = '0;
        end
      end
      RX_DATA: begin
        if (w_PeriodEnd) begin
          w_Shift_Nxt[r_Idx] = r_RxSync;
          w_Idx_Nxt          = r_Idx + 3'd1;
          if (r_Idx == 3'd7) w_State_Nxt = RX_STOP;
        end
      end
      RX_STOP: begin
        // Leaving at mid stop bit leaves half a bit to catch a back-to-back start.
        if (w_PeriodEnd) begin
          if (r_RxSync) begin
            w_Data_Nxt  = r_Shift;
            w_Valid_Nxt = 1'b1;
            w_State_Nxt = RX_IDLE;
          end else begin
            w_FrameErr_Nxt = 1'b1;
            w_State_Nxt    = RX_WAIT_HIGH;
          end
        end
      end
      RX_WAIT_HIGH: begin
        // A held-low line (break) must not look like a new start bit.
        w_Cnt_Nxt = '0;
        if (r_RxSync) w_State_Nxt = RX_IDLE;
      end
      default: begin
        w_State_Nxt = RX_IDLE;
        w_Cnt_Nxt   = '0;
      end
    endcase
  end

  assign rx.o_Data     = r_Data;
  assign rx.o_Valid    = r_Valid;
  assign rx.o_FrameErr = r_FrameErr;
  assign rx.o_Idle     = (r_State == RX_IDLE);

endmodule
